sc_wb_regbank: RTL
==================

# sc_wb_regbank

Synthesizable Wishbone-style slave register bank that sits directly downstream of the slow-control master. It terminates the 16-bit-address / 8-bit-data strobe bus and decodes accesses to three resources: a configuration register file, read-only status inputs, and a self-clearing command register. It generates `wb_ack` for every access, including illegal ones, so the master never stalls. A saturating counter records bad accesses.

## Interface
- `NUM_CFG`, default 32: number of 8-bit RW config registers (1..64).
- `BASE_ADDR`, default 16'h0000: bank base; offsets are `adr - BASE_ADDR`.
- `CFG_RESET`, default '0: flat `NUM_CFG*8`-bit reset image of config registers; register k takes bits [8k+7:8k].

Ports:
- `clk40MHz` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wb_adr_i` in 16: access address.
- `wb_wen_i` in 1: 1 = write, 0 = read; qualified by `wb_stb_i`.
- `wb_stb_i` in 1: access strobe.
- `wb_dat_i` in 8: write data.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `wb_dat_o` out 8: read data, valid while `wb_ack_o`=1.
- `cfg_o` out NUM_CFG*8: config register contents.
- `status_i` in 128: 16 read-only status bytes, synchronous to `clk40MHz`.
- `cmd_pulse_o` out 8: command strobes.

## Operation
Offset map:
- 0x00..NUM_CFG-1: config RW.
- 0x40..0x4F: status RO; writes are ignored and counted as bad.
- 0x7E: bad-access counter. Read returns the count; any write clears it to 0.
- 0x7F: command register. Writing `wb_dat_i` raises `cmd_pulse_o` = `wb_dat_i` for exactly one cycle. Reads return 0x00.
- Every other offset, including `adr < BASE_ADDR`, is bad. Writes are dropped, reads return 8'hEE.

Bad-access counter is 8 bits and saturates at 0xFF. It increments once per accepted bad access.

FSM `IDLE`, `ACK`, `HOLD`:
- `IDLE`: on `wb_stb_i`=1 at a clock edge, perform the access on that same edge. Writes update the target. Reads register the target into `wb_dat_o`. Go to `ACK`.
- `ACK`: `wb_ack_o`=1 for this one cycle. Next edge: go to `HOLD` if `wb_stb_i`=1, else to `IDLE`.
- `HOLD`: no access is accepted. Return to `IDLE` on the first edge that samples `wb_stb_i`=0.

Each strobe assertion therefore produces exactly one access and one ack, however long the strobe is held.

Outputs:
- `wb_dat_o` keeps its value outside ack. It is cleared to 0x00 on reset.
- `cfg_o` changes only on an accepted config write.

## Timing
- Access sampled at edge N. `wb_ack_o` is high from N until N+1. Read data is valid during the same window.
- A write to a config register is visible on `cfg_o` after edge N.
- `cmd_pulse_o` is high from N until N+1 and is otherwise 0.
- Status bytes are sampled at edge N, with no extra synchronization.
- Back-to-back: the minimum strobe-to-strobe spacing is one low-sampled edge after `ACK`/`HOLD`.
- If a bad access coincides with the counter at 0xFF, the counter holds 0xFF.
- Reset, asynchronous at any time, including mid-access:
  - state becomes `IDLE`
  - `wb_ack_o`=0, `wb_dat_o`=0x00, `cmd_pulse_o`=0
  - `cfg_o`=`CFG_RESET`
  - counter = 0
  - no pending ack survives reset.
- After reset deassertion, a strobe already high is treated as a new access on the first edge.

## Structure
- Package `sc_regbank_pkg`:
  - offset constants `OFS_STATUS_LO` (0x40), `OFS_STATUS_HI` (0x4F), `OFS_BADCNT` (0x7E), `OFS_CMD` (0x7F)
  - `BAD_READ_VAL` (8'hEE)
  - FSM enum `sc_state_t` {IDLE, ACK, HOLD}
  - region enum `sc_region_t` {REG_CFG, REG_STATUS, REG_BADCNT, REG_CMD, REG_BAD}.
- One sub-module: `sc_addr_decode`. It is combinational and maps `wb_adr_i`, `wb_wen_i` and `BASE_ADDR` to `sc_region_t` plus an index. The FSM, storage and counter live in the top.

## Test plan
- Reset with `CFG_RESET` byte 3 = 0xA5 → `cfg_o[31:24]`=0xA5, `wb_ack_o`=0, `wb_dat_o`=0x00.
- Write 0x3C to offset 0x05 with a one-cycle strobe → one ack pulse, `cfg_o[47:40]`=0x3C. Read 0x05 with strobe held 3 cycles → exactly one ack, `wb_dat_o`=0x3C.
- Set `status_i` byte 2 = 0x5A and read 0x42 → 0x5A. Write 0x11 to 0x42 → status unchanged, bad counter reads 0x01.
- Write 0x81 to 0x7F → `cmd_pulse_o`=0x81 for one cycle, then 0x00. Read 0x7F → 0x00.
- Read 0x1234 300 times → each ack returns 0xEE, counter saturates at 0xFF. Write any value to 0x7E → counter reads 0x00.
- Assert `rst` in the `ACK` cycle of a read → ack drops immediately, state is `IDLE`. Strobe still high after release → one new ack.

Source files
------------

// File: rtl/sc_wb_regbank_pkg.sv
// sc_regbank_pkg: shared constants and types for the slow-control register bank.
//   - offset constants for the status window, bad-access counter and command register
//   - BAD_READ_VAL: data returned for reads of unmapped offsets
//   - sc_state_t: bus FSM states (IDLE/ACK/HOLD)
//   - sc_region_t: decoded target region of an access
package sc_regbank_pkg;

  localparam logic [15:0] OFS_STATUS_LO = 16'h0040;
  localparam logic [15:0] OFS_STATUS_HI = 16'h004F;
  localparam logic [15:0] OFS_BADCNT    = 16'h007E;
  localparam logic [15:0] OFS_CMD       = 16'h007F;

  localparam logic [7:0]  BAD_READ_VAL  = 8'hEE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } sc_state_t;

  typedef enum logic [2:0] {
    REG_CFG    = 3'd0,
    REG_STATUS = 3'd1,
    REG_BADCNT = 3'd2,
    REG_CMD    = 3'd3,
    REG_BAD    = 3'd4
  } sc_region_t;

endpackage

// File: rtl/sc_wb_regbank_addr_decode.sv
// sc_addr_decode: combinational address decoder for the register bank.
// Ports:
//   wb_adr_i  in  16 : bus address
//   wb_wen_i  in  1  : 1 = write, 0 = read
//   region    out    : decoded target region (sc_region_t)
//   idx       out 6  : register index within the region (config or status)
// A write into the read-only status window decodes as REG_BAD so the top
// drops it and counts it like any other illegal access.
module sc_addr_decode
  import sc_regbank_pkg::*;
#(
  parameter int          NUM_CFG   = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic [15:0] wb_adr_i,
  input  logic        wb_wen_i,
  output sc_region_t  region,
  output logic [5:0]  idx
);

  localparam logic [15:0] NUM_CFG_W = 16'(NUM_CFG);

  // 17-bit subtraction: bit 16 set means the address lies below the base.
  logic [16:0] diff;
  logic [15:0] ofs;

  always_comb begin
    diff   = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
    ofs    = diff[15:0];
    idx    = ofs[5:0];
    region = REG_BAD;
    if (!diff[16]) begin
      if (ofs < NUM_CFG_W) begin
        region = REG_CFG;
      end else if ((ofs >= OFS_STATUS_LO) && (ofs <= OFS_STATUS_HI)) begin
        region = wb_wen_i ? REG_BAD : REG_STATUS;
      end else if (ofs == OFS_BADCNT) begin
        region = REG_BADCNT;
      end else if (ofs == OFS_CMD) begin
        region = REG_CMD;
      end
    end
  end

endmodule

// File: rtl/sc_wb_regbank.sv
// sc_wb_regbank: Wishbone-style slave register bank behind the slow-control master.
// Ports:
//   clk40MHz     in  1          : clock
//   rst          in  1          : asynchronous active-high reset
//   wb_adr_i     in  16         : access address
//   wb_wen_i     in  1          : 1 = write, 0 = read (qualified by wb_stb_i)
//   wb_stb_i     in  1          : access strobe
//   wb_dat_i     in  8          : write data
//   wb_ack_o     out 1          : one-cycle acknowledge
//   wb_dat_o     out 8          : read data, valid while wb_ack_o = 1
//   cfg_o        out NUM_CFG*8  : config register contents
//   status_i     in  128        : 16 read-only status bytes
//   cmd_pulse_o  out 8          : one-cycle command strobes
//   dbg_state    out 2          : current FSM state (sc_state_t encoding)
// Handshake: an access is taken on the first edge that sees wb_stb_i=1 in IDLE;
// wb_ack_o is high for exactly the following cycle; the strobe must then be
// sampled low once before another access is accepted. Every access, legal or
// not, is acknowledged.
module sc_wb_regbank
  import sc_regbank_pkg::*;
#(
  parameter int                  NUM_CFG   = 32,
  parameter logic [15:0]         BASE_ADDR = 16'h0000,
  parameter logic [NUM_CFG*8-1:0] CFG_RESET = '0
) (
  input  logic                 clk40MHz,
  input  logic                 rst,
  input  logic [15:0]          wb_adr_i,
  input  logic                 wb_wen_i,
  input  logic                 wb_stb_i,
  input  logic [7:0]           wb_dat_i,
  output logic                 wb_ack_o,
  output logic [7:0]           wb_dat_o,
  output logic [NUM_CFG*8-1:0] cfg_o,
  input  logic [127:0]         status_i,
  output logic [7:0]           cmd_pulse_o,
  output logic [1:0]           dbg_state
);

  sc_state_t            state_q;
  sc_region_t           region;
  logic [5:0]           idx;
  logic [7:0]           rd_data;
  logic [7:0]           badcnt_q;
  logic [NUM_CFG*8-1:0] cfg_q;

  sc_addr_decode #(
    .NUM_CFG   (NUM_CFG),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .wb_adr_i (wb_adr_i),
    .wb_wen_i (wb_wen_i),
    .region   (region),
    .idx      (idx)
  );

  // Read mux for the addressed byte; status is sampled directly (already
  // synchronous to clk40MHz).
  always_comb begin
    rd_data = BAD_READ_VAL;
    case (region)
      REG_CFG: begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (idx == k[5:0]) rd_data = cfg_q[k*8 +: 8];
        end
      end
      REG_STATUS: begin
        for (int s = 0; s < 16; s++) begin
          if (idx[3:0] == s[3:0]) rd_data = status_i[s*8 +: 8];
        end
      end
      REG_BADCNT: rd_data = badcnt_q;
      REG_CMD:    rd_data = 8'h00;
      default:    rd_data = BAD_READ_VAL;
    endcase
  end

  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wb_dat_o    <= 8'h00;
      cmd_pulse_o <= 8'h00;
      cfg_q       <= CFG_RESET;
      badcnt_q    <= 8'h00;
    end else begin
      // Command strobes live for the single ACK cycle only.
      cmd_pulse_o <= 8'h00;
      case (state_q)
        IDLE: begin
          if (wb_stb_i) begin
            state_q <= ACK;
            if (!wb_wen_i) begin
              wb_dat_o <= rd_data;
            end else begin
              case (region)
                REG_CFG: begin
                  for (int k = 0; k < NUM_CFG; k++) begin
                    if (idx == k[5:0]) cfg_q[k*8 +: 8] <= wb_dat_i;
                  end
                end
                REG_CMD:    cmd_pulse_o <= wb_dat_i;
                REG_BADCNT: badcnt_q    <= 8'h00;
                default: ;
              endcase
            end
            if ((region == REG_BAD) && (badcnt_q != 8'hFF)) begin
              badcnt_q <= badcnt_q + 8'h01;
            end
          end
        end
        ACK:     state_q <= wb_stb_i ? HOLD : IDLE;
        HOLD:    if (!wb_stb_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_ack_o  = (state_q == ACK);
  assign cfg_o     = cfg_q;
  assign dbg_state = state_q;

endmodule
